// File: rtl/cm_chan_gen_if.sv
// Channel generator bus: per-lane sample/interference/coefficient inputs,
// complex results, timestamp tag and status.
interface cm_chan_gen_if #(
   parameter int NCH = 3,
   parameter int W   = 16
);
   logic               in_valid;
   logic [NCH*W-1:0]   din;
   logic [NCH*W-1:0]   int_real;
   logic [NCH*W-1:0]   int_img;
   logic [NCH*W-1:0]   coef_real;
   logic [NCH*W-1:0]   coef_img;
   logic               scen_ch;
   logic [W-1:0]       ts_inc;
   logic [NCH*W-1:0]   out_real;
   logic [NCH*W-1:0]   out_img;
   logic               out_valid;
   logic [W-1:0]       ts_out;
   logic [7:0]         scen_cnt;
   logic               sat_flag;

   modport slave (
      input  in_valid, din, int_real, int_img, coef_real, coef_img, scen_ch, ts_inc,
      output out_real, out_img, out_valid, ts_out, scen_cnt, sat_flag
   );

   modport master (
      output in_valid, din, int_real, int_img, coef_real, coef_img, scen_ch, ts_inc,
      input  out_real, out_img, out_valid, ts_out, scen_cnt, sat_flag
   );
endinterface

// File: rtl/cm_chan_gen.sv
// Multi-channel complex gain + interference generator, fixed 2-cycle latency.
// Define CM_SAT_EN to clamp results and report sticky saturation; default wraps.
module cm_chan_gen #(
   parameter int NCH  = 3,
   parameter int W    = 16,
   parameter int FRAC = 14
) (
   input  logic          CLK,
   input  logic          reset,
   cm_chan_gen_if.slave  bus
);
   localparam int PW = 2 * W;
   localparam int SW = W + 2;
`ifdef CM_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif
   localparam logic [W-1:0] UNITY = W'(1) << FRAC;
   localparam logic [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SMIN  = {1'b1, {(W-1){1'b0}}};

   logic [NCH-1:0][W-1:0]  coef_re_q, coef_im_q;
   logic [W-1:0]           acc_q, acc_d, tag;
   logic [7:0]             scen_cnt_q;
   logic [2:1]             vld_pipe_q;
   logic                   sat_q, sat_d;

   logic [NCH-1:0][PW-1:0] prod_re, prod_im, prod_re_q, prod_im_q;
   logic [NCH-1:0][W-1:0]  int_re_q, int_im_q;
   logic [W-1:0]           ts1_q, ts_out_q;
   logic [NCH-1:0][W-1:0]  nar_re, nar_im, out_re_q, out_im_q;
   logic [NCH-1:0]         clp_re, clp_im;

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      logic signed [SW-1:0] sum_re, sum_im;

      // Products use the coefficients active before any same-cycle scen_ch load.
      assign prod_re[k] = PW'($signed(bus.din[k*W +: W])) * PW'($signed(coef_re_q[k]));
      assign prod_im[k] = PW'($signed(bus.din[k*W +: W])) * PW'($signed(coef_im_q[k]));

      assign sum_re = SW'($signed(prod_re_q[k]) >>> FRAC) + SW'($signed(int_re_q[k]));
      assign sum_im = SW'($signed(prod_im_q[k]) >>> FRAC) + SW'($signed(int_im_q[k]));

      // Sum fits in W bits only when its top three bits agree.
      assign clp_re[k] = SAT_EN && (sum_re[SW-1:W-1] != {(SW-W+1){sum_re[SW-1]}});
      assign clp_im[k] = SAT_EN && (sum_im[SW-1:W-1] != {(SW-W+1){sum_im[SW-1]}});

      assign nar_re[k] = clp_re[k] ? (sum_re[SW-1] ? SMIN : SMAX) : sum_re[W-1:0];
      assign nar_im[k] = clp_im[k] ? (sum_im[SW-1] ? SMIN : SMAX) : sum_im[W-1:0];
   end

   always_comb begin
      tag   = acc_q + bus.ts_inc;
      acc_d = acc_q;
      if (bus.scen_ch)       acc_d = '0;
      else if (bus.in_valid) acc_d = tag;
      sat_d = sat_q | (vld_pipe_q[1] & (|{clp_re, clp_im}));
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         vld_pipe_q <= '0;
         acc_q      <= '0;
         scen_cnt_q <= '0;
         sat_q      <= 1'b0;
         coef_re_q  <= {NCH{UNITY}};
         coef_im_q  <= '0;
         prod_re_q  <= '0;
         prod_im_q  <= '0;
         int_re_q   <= '0;
         int_im_q   <= '0;
         ts1_q      <= '0;
         ts_out_q   <= '0;
         out_re_q   <= '0;
         out_im_q   <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[1], bus.in_valid};
         acc_q      <= acc_d;
         sat_q      <= sat_d;
         if (bus.scen_ch) begin
            coef_re_q  <= bus.coef_real;
            coef_im_q  <= bus.coef_img;
            scen_cnt_q <= scen_cnt_q + 8'd1;
         end
         if (bus.in_valid) begin
            prod_re_q <= prod_re;
            prod_im_q <= prod_im;
            int_re_q  <= bus.int_real;
            int_im_q  <= bus.int_img;
            ts1_q     <= tag;
         end
         // Outputs hold through bubbles.
         if (vld_pipe_q[1]) begin
            out_re_q <= nar_re;
            out_im_q <= nar_im;
            ts_out_q <= ts1_q;
         end
      end
   end

   assign bus.out_real  = out_re_q;
   assign bus.out_img   = out_im_q;
   assign bus.out_valid = vld_pipe_q[2];
   assign bus.ts_out    = ts_out_q;
   assign bus.scen_cnt  = scen_cnt_q;
   assign bus.sat_flag  = sat_q;
endmodule

// File: doc/cm_chan_gen.md
CM_CHAN_GEN -- requirements
Module: cm_chan_gen

Interface
REQ-001 SHALL have parameter NCH, default 3: number of independent channels.
REQ-002 SHALL have parameter W, default 16: sample, coefficient and timestamp width.
REQ-003 SHALL have parameter FRAC, default 14: coefficient fractional bits.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: all din/int lanes valid this cycle.
REQ-007 SHALL have port din, input, NCH*W bits: real signed sample per channel, lane k at bits [k*W +: W].
REQ-008 SHALL have ports int_real and int_img, input, NCH*W bits each: signed complex interference per channel.
REQ-009 SHALL have ports coef_real and coef_img, input, NCH*W bits each: signed complex coefficient per channel, sampled only on scen_ch.
REQ-010 SHALL have port scen_ch, input, 1 bit: scenario-change pulse.
REQ-011 SHALL have port ts_inc, input, W bits: timestamp increment per valid sample.
REQ-012 SHALL have ports out_real and out_img, output, NCH*W bits each: signed complex result per channel.
REQ-013 SHALL have port out_valid, output, 1 bit: out_real/out_img/ts_out valid.
REQ-014 SHALL have port ts_out, output, W bits: timestamp tag aligned with the outputs.
REQ-015 SHALL have port scen_cnt, output, 8 bits: count of scenario changes.
REQ-016 SHALL have port sat_flag, output, 1 bit: sticky saturation indicator.

Function
REQ-017 SHALL compute per lane k: out_k = sat_or_wrap(((din_k*coefA_k) >>> FRAC) + int_k), separately for the real part (coefA_real) and the imaginary part (coefA_img).
REQ-018 SHALL form the product at full 2W-bit signed width, then apply an arithmetic right shift (floor truncation), sign-extend int, and sum at W+2 bits before narrowing.
REQ-019 SHALL use a 2-stage pipeline with fixed latency 2: stage 1 registers products, stage 2 registers sums; no backpressure.
REQ-020 SHALL assert out_valid exactly 2 cycles after each in_valid=1; bubbles propagate, and outputs hold their last value when out_valid=0.
REQ-021 SHALL hold active coefficients coefA per lane; a cycle with scen_ch=1 loads coefA from coef_real/coef_img at that edge.
REQ-022 SHALL process an in_valid sample in the same cycle as scen_ch with the old coefficients; new coefficients apply from the next cycle on.
REQ-023 SHALL tag each in_valid sample with acc+ts_inc, where acc is a W-bit accumulator wrapping modulo 2^W.
REQ-024 SHALL update acc as: scen_ch=1 -> 0 (priority); else in_valid=1 -> acc+ts_inc; else hold.
REQ-025 SHALL carry the tag through the pipeline to ts_out.
REQ-026 SHALL increment scen_cnt by 1 per scen_ch cycle, wrapping 255 -> 0.

Reset
REQ-027 SHALL, on reset low, immediately clear out_real, out_img, ts_out, acc, scen_cnt, sat_flag and out_valid to 0 and flush pipeline valids, regardless of CLK.
REQ-028 SHALL, on reset, set coefA to unity (real = 2^FRAC, imag = 0) on all lanes.
REQ-029 SHALL discard any in-flight sample when reset asserts mid-stream, producing no out_valid for it after release.

Configuration
REQ-030 SHALL, with macro CM_SAT_EN defined, clamp each sum to [-2^(W-1), 2^(W-1)-1] and set sat_flag, sticky until reset, when any lane clamps on a valid sample.
REQ-031 SHALL, without CM_SAT_EN, wrap each sum to its low W bits and tie sat_flag to 0.

Verification (W=16, FRAC=14, NCH=3)
REQ-032 SHALL verify: after reset, din0=1000, int0=(5,-3), in_valid pulse -> 2 cycles later out_valid=1, out0=(1005,-3).
REQ-033 SHALL verify: scen_ch with coef0=(0,16384) and din0=2000 in the same cycle -> out0=(2000,0); next-cycle din0=2000 -> out0=(0,2000); scen_cnt=1.
REQ-034 SHALL verify: din0=32767, coef unity, int0_real=100 -> CM_SAT_EN: out0_real=32767 and sat_flag=1; without: out0_real=-32669 and sat_flag=0.
REQ-035 SHALL verify: din0=-3, coef0=(8192,0) -> out0_real=-2 (floor truncation).
REQ-036 SHALL verify: ts_inc=0x8000 with 3 valid samples -> ts_out=0x8000, 0x0000, 0x8000; a later scen_ch followed by ts_inc=1 with one valid -> ts_out=0x0001.
REQ-037 SHALL verify: reset pulsed one cycle after in_valid -> no out_valid after release, coefs read back unity, scen_cnt=0.
